// File: rtl/wb_arbiter_pkg.sv
// Shared types for the write-back arbiter: source identifiers and the
// buffered result record. Supplies default widths when WORD_SIZE /
// ROB_ENTRY_WIDTH are not defined on the command line.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package wb_arbiter_pkg;
  localparam int WB_WORD_W     = `WORD_SIZE;
  localparam int WB_ROB_W      = `ROB_ENTRY_WIDTH;
  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_MUL = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic [WB_WORD_W-1:0] data;
    logic [WB_ROB_W-1:0]  rob_id;
  } wb_result_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-entry result buffer for one execution unit. Entry 0 is always the
// head; a pop shifts entry 1 down. Ready depends only on the registered
// occupancy, so there is no path from the arbiter's grant back to ready.
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ID_W-1:0]   push_id,
  output logic              ready,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ID_W-1:0]   head_id
);
  logic [1:0]        count;
  logic [DATA_W-1:0] data0, data1;
  logic [ID_W-1:0]   id0, id1;
  logic              push, do_pop;

  assign ready      = (count < 2'd2);
  assign push       = push_valid && ready && !flush;
  assign do_pop     = pop && (count != 2'd0) && !flush;
  assign head_valid = (count != 2'd0);
  assign head_data  = head_valid ? data0 : '0;
  assign head_id    = head_valid ? id0 : '0;

  // Occupancy and storage update: flush empties, push/pop shift in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      id0   <= '0;
      id1   <= '0;
    end else if (flush) begin
      count <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      id0   <= '0;
      id1   <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            data0 <= push_data;
            id0   <= push_id;
          end else begin
            data1 <= push_data;
            id1   <= push_id;
          end
        end
        2'b01: begin
          count <= count - 2'd1;
          data0 <= data1;
          id0   <= id1;
          data1 <= '0;
          id1   <= '0;
        end
        2'b11: begin
          // Occupancy holds; the new entry lands behind whatever remains.
          if (count == 2'd1) begin
            data0 <= push_data;
            id0   <= push_id;
          end else begin
            data0 <= data1;
            id0   <= id1;
            data1 <= push_data;
            id1   <= push_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU/MEM/MUL results in per-unit FIFOs,
// exposes each FIFO head on the bypass network and writes one result per
// cycle into the ROB (mul > mem > alu).
// Optional feature: define WB_AGING_EN to add age counters for alu/mem so
// a source waiting AGE_LIMIT cycles is forced to win (alu before mem).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int AGE_LIMIT       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alu_valid_in,
  input  logic [WORD_SIZE-1:0]       alu_data_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id_in,
  output logic                       alu_ready_out,
  input  logic                       mem_valid_in,
  input  logic [WORD_SIZE-1:0]       mem_data_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id_in,
  output logic                       mem_ready_out,
  input  logic                       mul_valid_in,
  input  logic [WORD_SIZE-1:0]       mul_data_in,
  input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id_in,
  output logic                       mul_ready_out,
  output logic [WORD_SIZE-1:0]       alu_data,
  output logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
  output logic                       alu_bypass_enable,
  output logic [WORD_SIZE-1:0]       mem_data,
  output logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
  output logic                       mem_bypass_enable,
  output logic [WORD_SIZE-1:0]       mul_data,
  output logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
  output logic                       mul_bypass_enable,
  output logic                       rob_wr_en,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_entry,
  output logic [WORD_SIZE-1:0]       rob_wr_data
);
  if (AGE_LIMIT < 1) begin : g_bad_age_limit
    $error("AGE_LIMIT must be at least 1");
  end

  logic    alu_hv, mem_hv, mul_hv;
  logic    alu_pop, mem_pop, mul_pop;
  logic    gnt_valid;
  wb_src_t gnt_src;

  wb_fifo #(.DATA_W(WORD_SIZE), .ID_W(ROB_ENTRY_WIDTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(alu_valid_in), .push_data(alu_data_in), .push_id(alu_rob_id_in),
    .ready(alu_ready_out), .pop(alu_pop),
    .head_valid(alu_hv), .head_data(alu_data), .head_id(alu_rob_id)
  );

  wb_fifo #(.DATA_W(WORD_SIZE), .ID_W(ROB_ENTRY_WIDTH)) u_mem_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(mem_valid_in), .push_data(mem_data_in), .push_id(mem_rob_id_in),
    .ready(mem_ready_out), .pop(mem_pop),
    .head_valid(mem_hv), .head_data(mem_data), .head_id(mem_rob_id)
  );

  wb_fifo #(.DATA_W(WORD_SIZE), .ID_W(ROB_ENTRY_WIDTH)) u_mul_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(mul_valid_in), .push_data(mul_data_in), .push_id(mul_rob_id_in),
    .ready(mul_ready_out), .pop(mul_pop),
    .head_valid(mul_hv), .head_data(mul_data), .head_id(mul_rob_id)
  );

  // The bypass network is silenced for the whole flush cycle.
  assign alu_bypass_enable = alu_hv && !flush;
  assign mem_bypass_enable = mem_hv && !flush;
  assign mul_bypass_enable = mul_hv && !flush;

`ifdef WB_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_alu, age_mem;
  logic             alu_starved, mem_starved;

  assign alu_starved = alu_hv && (age_alu >= AGE_MAX);
  assign mem_starved = mem_hv && (age_mem >= AGE_MAX);

  // Age counters: count lost arbitration cycles, saturate at AGE_LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_alu <= '0;
      age_mem <= '0;
    end else if (flush) begin
      age_alu <= '0;
      age_mem <= '0;
    end else begin
      if (!alu_hv || alu_pop) age_alu <= '0;
      else if (age_alu != AGE_MAX) age_alu <= age_alu + AGE_W'(1);
      if (!mem_hv || mem_pop) age_mem <= '0;
      else if (age_mem != AGE_MAX) age_mem <= age_mem + AGE_W'(1);
    end
  end
`endif

  // Grant selection: starved sources first (when aging), then mul > mem > alu.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_ALU;
    if (!flush) begin
`ifdef WB_AGING_EN
      if (alu_starved) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
      end else if (mem_starved) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_MEM;
      end else
`endif
      if (mul_hv) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_MUL;
      end else if (mem_hv) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_MEM;
      end else if (alu_hv) begin
        gnt_valid = 1'b1;
        gnt_src   = SRC_ALU;
      end
    end
  end

  assign alu_pop = gnt_valid && (gnt_src == SRC_ALU);
  assign mem_pop = gnt_valid && (gnt_src == SRC_MEM);
  assign mul_pop = gnt_valid && (gnt_src == SRC_MUL);

  // ROB write port driven straight from the granted head; zero when idle.
  always_comb begin
    rob_wr_en    = 1'b0;
    rob_wr_entry = '0;
    rob_wr_data  = '0;
    if (gnt_valid) begin
      rob_wr_en = 1'b1;
      case (gnt_src)
        SRC_ALU: begin
          rob_wr_entry = alu_rob_id;
          rob_wr_data  = alu_data;
        end
        SRC_MEM: begin
          rob_wr_entry = mem_rob_id;
          rob_wr_data  = mem_data;
        end
        default: begin
          rob_wr_entry = mul_rob_id;
          rob_wr_data  = mul_data;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run compared against a queue-based reference model.
`timescale 1ns/1ps
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int WW  = `WORD_SIZE;
  localparam int RW  = `ROB_ENTRY_WIDTH;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          vin[3];
  logic [WW-1:0] din[3];
  logic [RW-1:0] iin[3];
  logic          rdy[3];
  logic          bv[3];
  logic [WW-1:0] bd[3];
  logic [RW-1:0] bi[3];
  logic          rob_wr_en;
  logic [RW-1:0] rob_wr_entry;
  logic [WW-1:0] rob_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // index 0 = alu, 1 = mem, 2 = mul
  wb_arbiter #(.WORD_SIZE(WW), .ROB_ENTRY_WIDTH(RW), .AGE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid_in(vin[0]), .alu_data_in(din[0]), .alu_rob_id_in(iin[0]), .alu_ready_out(rdy[0]),
    .mem_valid_in(vin[1]), .mem_data_in(din[1]), .mem_rob_id_in(iin[1]), .mem_ready_out(rdy[1]),
    .mul_valid_in(vin[2]), .mul_data_in(din[2]), .mul_rob_id_in(iin[2]), .mul_ready_out(rdy[2]),
    .alu_data(bd[0]), .alu_rob_id(bi[0]), .alu_bypass_enable(bv[0]),
    .mem_data(bd[1]), .mem_rob_id(bi[1]), .mem_bypass_enable(bv[1]),
    .mul_data(bd[2]), .mul_rob_id(bi[2]), .mul_bypass_enable(bv[2]),
    .rob_wr_en(rob_wr_en), .rob_wr_entry(rob_wr_entry), .rob_wr_data(rob_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    for (int s = 0; s < 3; s++) begin
      vin[s] = 1'b0;
      din[s] = '0;
      iin[s] = '0;
    end
  endtask

  task automatic set_src(input int s, input logic v, input int id, input int d);
    vin[s] = v;
    iin[s] = RW'(id);
    din[s] = WW'(d);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy[0], rdy[1], rdy[2]} !== 3'b111) begin
      n_bad++; $display("FAIL reset_ready_async: got %b expected 111", {rdy[0], rdy[1], rdy[2]});
    end
    n_cmp++;
    if (rob_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_wr_en_async: got %b expected 0", rob_wr_en);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bv[0], bv[1], bv[2]} !== 3'b000) begin
      n_bad++; $display("FAIL reset_bypass: got %b expected 000", {bv[0], bv[1], bv[2]});
    end
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (bd[s] !== '0 || bi[s] !== '0) begin
        n_bad++; $display("FAIL reset_bypass_data[%0d]: got %0h/%0h expected 0/0", s, bd[s], bi[s]);
      end
    end
    n_cmp++;
    if ({rob_wr_en, rob_wr_entry, rob_wr_data} !== '0) begin
      n_bad++; $display("FAIL reset_rob: got en=%b entry=%0h data=%0h expected all 0", rob_wr_en, rob_wr_entry, rob_wr_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 1'b1, 3, 'h11);
    tick();
    idle_inputs();
    n_cmp++;
    if (bv[0] !== 1'b1 || bi[0] !== RW'(3) || bd[0] !== WW'('h11)) begin
      n_bad++; $display("FAIL single_bypass: got en=%b id=%0d data=%0h expected 1/3/11", bv[0], bi[0], bd[0]);
    end
    n_cmp++;
    if (rob_wr_en !== 1'b1 || rob_wr_entry !== RW'(3) || rob_wr_data !== WW'('h11)) begin
      n_bad++; $display("FAIL single_rob: got en=%b entry=%0d data=%0h expected 1/3/11", rob_wr_en, rob_wr_entry, rob_wr_data);
    end
    tick();
    n_cmp++;
    if (bv[0] !== 1'b0 || rob_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL single_after: got bypass=%b wr_en=%b expected 0/0", bv[0], rob_wr_en);
    end
  endtask

  task automatic test_same_cycle();
    int exp_ids[3] = '{3, 2, 1};
    do_reset();
    set_src(0, 1'b1, 1, 'hA1);
    set_src(1, 1'b1, 2, 'hB2);
    set_src(2, 1'b1, 3, 'hC3);
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (rob_wr_en !== 1'b1 || rob_wr_entry !== RW'(exp_ids[k])) begin
        n_bad++; $display("FAIL same_cycle_order[%0d]: got en=%b entry=%0d expected 1/%0d", k, rob_wr_en, rob_wr_entry, exp_ids[k]);
      end
      tick();
    end
    n_cmp++;
    if (rob_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_drained: got wr_en=%b expected 0", rob_wr_en);
    end
  endtask

  task automatic test_starvation();
    int last;
    do_reset();
`ifdef WB_AGING_EN
    last = 5;
`else
    last = 8;
`endif
    set_src(0, 1'b1, 5, 'h55);
    set_src(2, 1'b1, 17, 'h1700);
    for (int k = 1; k <= last; k++) begin
      tick();
      vin[0] = 1'b0;
      set_src(2, 1'b1, 17 + k, 'h1700 + k);
`ifdef WB_AGING_EN
      if (k == 5) begin
        n_cmp++;
        if (rob_wr_en !== 1'b1 || rob_wr_entry !== RW'(5) || rob_wr_data !== WW'('h55)) begin
          n_bad++; $display("FAIL aging_win: cycle %0d got en=%b entry=%0d expected 1/5", k, rob_wr_en, rob_wr_entry);
        end
        continue;
      end
`endif
      n_cmp++;
      if (rob_wr_en !== 1'b1 || rob_wr_entry !== RW'(16 + k) || bv[0] !== 1'b1) begin
        n_bad++; $display("FAIL starve_mul_wins: cycle %0d got en=%b entry=%0d alu_bypass=%b expected 1/%0d/1", k, rob_wr_en, rob_wr_entry, bv[0], 16 + k);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_order();
    int ptr = 0;
    logic seen_ready;
    int got[$];
    logic mem_won;
    do_reset();
    set_src(2, 1'b1, 20, 'h2000);
    set_src(1, 1'b1, 7, 'h700);
    seen_ready = rdy[1];
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (vin[1] && seen_ready) ptr++;
      mem_won = rob_wr_en && (rob_wr_entry >= RW'(7)) && (rob_wr_entry <= RW'(9));
      if (mem_won) got.push_back(int'(rob_wr_entry));
`ifndef WB_AGING_EN
      if (cyc <= 10) begin
        n_cmp++;
        if (mem_won !== 1'b0) begin
          n_bad++; $display("FAIL full_mem_granted_while_mul_busy: cycle %0d got entry=%0d expected mul", cyc, rob_wr_entry);
        end
      end
`endif
      if (cyc == 2 || cyc == 3) begin
        n_cmp++;
        if (rdy[1] !== 1'b0 || bi[1] !== RW'(7)) begin
          n_bad++; $display("FAIL full_mem_ready: cycle %0d got ready=%b head=%0d expected 0/7", cyc, rdy[1], bi[1]);
        end
      end
      vin[1] = (ptr < 3);
      iin[1] = RW'(7 + ptr);
      din[1] = WW'('h700 + ptr);
      vin[2] = (cyc < 10);
      seen_ready = rdy[1];
    end
    idle_inputs();
    n_cmp++;
    if (got.size() !== 3) begin
      n_bad++; $display("FAIL full_count: got %0d writes expected 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (got[k] !== 7 + k) begin
          n_bad++; $display("FAIL full_order[%0d]: got %0d expected %0d", k, got[k], 7 + k);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_src(0, 1'b1, 1, 'h10);
    set_src(1, 1'b1, 2, 'h20);
    set_src(2, 1'b1, 3, 'h30);
    tick();
    set_src(0, 1'b1, 4, 'h40);
    set_src(1, 1'b1, 5, 'h50);
    set_src(2, 1'b1, 6, 'h60);
    tick();
    n_cmp++;
    if ({rdy[0], rdy[1]} !== 2'b00) begin
      n_bad++; $display("FAIL flush_prefill_full: got %b expected 00", {rdy[0], rdy[1]});
    end
    flush = 1'b1;
    set_src(2, 1'b1, 9, 'h90);
    #1;
    n_cmp++;
    if (rob_wr_en !== 1'b0 || {bv[0], bv[1], bv[2]} !== 3'b000) begin
      n_bad++; $display("FAIL flush_cycle: got wr_en=%b bypass=%b expected 0/000", rob_wr_en, {bv[0], bv[1], bv[2]});
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if ({rdy[0], rdy[1], rdy[2]} !== 3'b111 || {bv[0], bv[1], bv[2]} !== 3'b000 || rob_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL flush_after: got ready=%b bypass=%b wr_en=%b expected 111/000/0", {rdy[0], rdy[1], rdy[2]}, {bv[0], bv[1], bv[2]}, rob_wr_en);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_src(0, 1'b1, 1, 'h10);
    set_src(1, 1'b1, 2, 'h20);
    tick();
    idle_inputs();
    n_cmp++;
    if (rob_wr_en !== 1'b1 || rob_wr_entry !== RW'(2)) begin
      n_bad++; $display("FAIL async_pre: got en=%b entry=%0d expected 1/2", rob_wr_en, rob_wr_entry);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rob_wr_en !== 1'b0 || {bv[0], bv[1], bv[2]} !== 3'b000 || {rdy[0], rdy[1], rdy[2]} !== 3'b111 || rob_wr_entry !== '0) begin
      n_bad++; $display("FAIL async_assert: got wr_en=%b bypass=%b ready=%b entry=%0d expected 0/000/111/0", rob_wr_en, {bv[0], bv[1], bv[2]}, {rdy[0], rdy[1], rdy[2]}, rob_wr_entry);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (rob_wr_en !== 1'b0 || {bv[0], bv[1], bv[2]} !== 3'b000) begin
        n_bad++; $display("FAIL async_residual[%0d]: got wr_en=%b bypass=%b expected 0/000", k, rob_wr_en, {bv[0], bv[1], bv[2]});
      end
    end
  endtask

  task automatic test_random();
    wb_result_t mq[3][$];
    int wt[3];
    logic exp_rdy[3];
    logic exp_bv[3];
    int g;
    int p;
    wb_result_t r;
    do_reset();
    for (int s = 0; s < 3; s++) wt[s] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      p = (cyc < 300) ? 70 : 35;
      for (int s = 0; s < 3; s++) begin
        vin[s] = ($urandom_range(0, 99) < p);
        iin[s] = RW'($urandom);
        din[s] = WW'($urandom);
      end
      flush = ($urandom_range(0, 39) == 0);
      #1;
      // model: results waiting per unit, oldest first
      g = -1;
      for (int s = 0; s < 3; s++) begin
        exp_rdy[s] = (mq[s].size() < 2);
        exp_bv[s]  = !flush && (mq[s].size() > 0);
      end
      if (!flush) begin
`ifdef WB_AGING_EN
        if (mq[0].size() > 0 && wt[0] >= LIM) g = 0;
        else if (mq[1].size() > 0 && wt[1] >= LIM) g = 1;
        else
`endif
        if (mq[2].size() > 0) g = 2;
        else if (mq[1].size() > 0) g = 1;
        else if (mq[0].size() > 0) g = 0;
      end
      n_cmp++;
      if ({rdy[0], rdy[1], rdy[2]} !== {exp_rdy[0], exp_rdy[1], exp_rdy[2]}) begin
        n_bad++; $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, {rdy[0], rdy[1], rdy[2]}, {exp_rdy[0], exp_rdy[1], exp_rdy[2]});
      end
      n_cmp++;
      if ({bv[0], bv[1], bv[2]} !== {exp_bv[0], exp_bv[1], exp_bv[2]}) begin
        n_bad++; $display("FAIL rand_bypass_en: cycle %0d got %b expected %b", cyc, {bv[0], bv[1], bv[2]}, {exp_bv[0], exp_bv[1], exp_bv[2]});
      end
      for (int s = 0; s < 3; s++) begin
        if (exp_bv[s]) begin
          n_cmp++;
          if (bd[s] !== mq[s][0].data || bi[s] !== mq[s][0].rob_id) begin
            n_bad++; $display("FAIL rand_bypass_head[%0d]: cycle %0d got %0h/%0d expected %0h/%0d", s, cyc, bd[s], bi[s], mq[s][0].data, mq[s][0].rob_id);
          end
        end
      end
      n_cmp++;
      if (g < 0) begin
        if ({rob_wr_en, rob_wr_entry, rob_wr_data} !== '0) begin
          n_bad++; $display("FAIL rand_rob_idle: cycle %0d got en=%b entry=%0d data=%0h expected 0/0/0", cyc, rob_wr_en, rob_wr_entry, rob_wr_data);
        end
      end else if (rob_wr_en !== 1'b1 || rob_wr_entry !== mq[g][0].rob_id || rob_wr_data !== mq[g][0].data) begin
        n_bad++; $display("FAIL rand_rob_write: cycle %0d got en=%b entry=%0d data=%0h expected 1/%0d/%0h (src %0d)", cyc, rob_wr_en, rob_wr_entry, rob_wr_data, mq[g][0].rob_id, mq[g][0].data, g);
      end
      // model: effect of the coming clock edge
      if (flush) begin
        for (int s = 0; s < 3; s++) begin
          mq[s].delete();
          wt[s] = 0;
        end
      end else begin
        for (int s = 0; s < 3; s++) begin
          if (mq[s].size() > 0 && s != g) wt[s] = (wt[s] < LIM) ? wt[s] + 1 : LIM;
          else wt[s] = 0;
        end
        if (g >= 0) void'(mq[g].pop_front());
        for (int s = 0; s < 3; s++) begin
          if (vin[s] && exp_rdy[s]) begin
            r.data   = din[s];
            r.rob_id = iin[s];
            mq[s].push_back(r);
          end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_same_cycle();
    test_starvation();
    test_full_order();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
